// File: rtl/serial_bus_responder_pkg.sv
// Shared types for the serial bus responder: FSM states, byte kinds and bus-select helpers.
package serial_bus_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_LO,
        S_WAIT,
        S_TX,
        S_WRITE
    } sbr_state_t;

    typedef enum logic [1:0] {
        K_PC,
        K_MAR,
        K_MDR
    } sbr_kind_t;

    function automatic logic multi_sel(input logic pc, input logic mar, input logic mdr);
        return (pc & mar) | (pc & mdr) | (mar & mdr);
    endfunction

    function automatic sbr_kind_t sel_kind(input logic mar, input logic mdr);
        if (mar) return K_MAR;
        if (mdr) return K_MDR;
        return K_PC;
    endfunction

endpackage

// File: rtl/serial_bus_responder_if.sv
// Core <-> memory-side serial bus: qualified byte stream from the core, response bytes back.
interface serial_bus_responder_if;
    import serial_bus_responder_pkg::*;

    logic              bus_pc;
    logic              bus_mar;
    logic              bus_mdr;
    logic              halt;
    logic [BYTE_W-1:0] out_bus;
    logic [BYTE_W-1:0] in_bus;
    logic              ard_data_ready;
    logic              ard_receive_ready;

    modport master (
        output bus_pc, bus_mar, bus_mdr, halt, out_bus,
        input  in_bus, ard_data_ready, ard_receive_ready
    );

    modport slave (
        input  bus_pc, bus_mar, bus_mdr, halt, out_bus,
        output in_bus, ard_data_ready, ard_receive_ready
    );

endinterface

// File: rtl/serial_bus_responder_word_mem.sv
// Word memory, DEPTH x 16: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, write lands on the next rising edge.
// Backpressure: none; contents are never reset.
module sbr_word_mem
    import serial_bus_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WORD_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WORD_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/serial_bus_responder.sv
// Memory-side responder for the core's 8-bit serial bus; SBR_ROM_PROTECT_EN write-protects low words.
// Latency: RESP_LAT idle cycles after the last address byte, then one response byte per cycle.
// Backpressure: ard_receive_ready drops while a response or write is in flight.
module serial_bus_responder
    import serial_bus_responder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RESP_LAT  = 2,
    parameter int TIMEOUT   = 15,
    parameter int ROM_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_bus_responder_if.slave bus,
    output logic                  proto_err,
    input  logic                  init_we,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [WORD_W-1:0]     init_data
);

    localparam int TMO_W = (TIMEOUT > 1)  ? $clog2(TIMEOUT)  : 1;
    localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

`ifdef SBR_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    sbr_state_t        state_q, state_nxt;
    sbr_kind_t         kind_q, kind_nxt;
    logic [BYTE_W-1:0] hi_q, hi_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [WORD_W-1:0] data_q, data_nxt;
    logic              mdr_valid_q, mdr_valid_nxt;
    logic              fetch_q, fetch_nxt;
    logic [TMO_W-1:0]  tmo_q, tmo_nxt;
    logic [LAT_W-1:0]  lat_q, lat_nxt;
    logic [1:0]        byte_q, byte_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] rd_a, rd_b;

    logic              rrdy, drdy, take, clash;
    logic [BYTE_W-1:0] tx_byte;
    logic [WORD_W-1:0] word;
    sbr_kind_t         in_kind;

    sbr_word_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (addr_q),
        .rdata_a (rd_a),
        .raddr_b (addr_q + ADDR_W'(1)),
        .rdata_b (rd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            kind_q      <= K_PC;
            hi_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mdr_valid_q <= 1'b0;
            fetch_q     <= 1'b0;
            tmo_q       <= '0;
            lat_q       <= '0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_nxt;
            kind_q      <= kind_nxt;
            hi_q        <= hi_nxt;
            addr_q      <= addr_nxt;
            data_q      <= data_nxt;
            mdr_valid_q <= mdr_valid_nxt;
            fetch_q     <= fetch_nxt;
            tmo_q       <= tmo_nxt;
            lat_q       <= lat_nxt;
            byte_q      <= byte_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        kind_nxt      = kind_q;
        hi_nxt        = hi_q;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        mdr_valid_nxt = mdr_valid_q;
        fetch_nxt     = fetch_q;
        tmo_nxt       = tmo_q;
        lat_nxt       = lat_q;
        byte_nxt      = byte_q;
        mem_we        = 1'b0;
        mem_waddr     = init_addr;
        mem_wdata     = init_data;
        proto_err     = 1'b0;
        drdy          = 1'b0;
        tx_byte       = '0;

        // Ready is forced low while reset is asserted, not just after it releases.
        rrdy    = rst && (state_q == S_IDLE || state_q == S_RX_LO);
        take    = rrdy && !bus.halt && (bus.bus_pc | bus.bus_mar | bus.bus_mdr)
                  && !multi_sel(bus.bus_pc, bus.bus_mar, bus.bus_mdr);
        clash   = rrdy && !bus.halt && multi_sel(bus.bus_pc, bus.bus_mar, bus.bus_mdr);
        in_kind = sel_kind(bus.bus_mar, bus.bus_mdr);
        word    = {hi_q, bus.out_bus};

        if (clash) proto_err = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (init_we) begin
                    mem_we = 1'b1;
                    if (take) proto_err = 1'b1;
                end else if (take) begin
                    hi_nxt    = bus.out_bus;
                    kind_nxt  = in_kind;
                    tmo_nxt   = '0;
                    state_nxt = S_RX_LO;
                end
            end
            S_RX_LO: begin
                if (take) begin
                    if (in_kind != kind_q) begin
                        proto_err = 1'b1;
                        hi_nxt    = bus.out_bus;
                        kind_nxt  = in_kind;
                        tmo_nxt   = '0;
                    end else begin
                        lat_nxt  = '0;
                        byte_nxt = '0;
                        addr_nxt = word[ADDR_W-1:0];
                        case (kind_q)
                            K_MDR: begin
                                data_nxt      = word;
                                mdr_valid_nxt = 1'b1;
                                state_nxt     = S_IDLE;
                            end
                            K_PC: begin
                                fetch_nxt = 1'b1;
                                state_nxt = S_WAIT;
                            end
                            default: begin
                                fetch_nxt = 1'b0;
                                state_nxt = mdr_valid_q ? S_WRITE : S_WAIT;
                            end
                        endcase
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    proto_err = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    tmo_nxt = tmo_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(RESP_LAT - 1)) state_nxt = S_TX;
                else                               lat_nxt   = lat_q + 1'b1;
            end
            S_TX: begin
                drdy = 1'b1;
                case (byte_q)
                    2'd0:    tx_byte = rd_a[15:8];
                    2'd1:    tx_byte = rd_a[7:0];
                    2'd2:    tx_byte = rd_b[15:8];
                    default: tx_byte = rd_b[7:0];
                endcase
                if (byte_q == (fetch_q ? 2'd3 : 2'd1)) state_nxt = S_IDLE;
                else                                    byte_nxt  = byte_q + 1'b1;
            end
            S_WRITE: begin
                mem_waddr     = addr_q;
                mem_wdata     = data_q;
                mdr_valid_nxt = 1'b0;
                state_nxt     = S_IDLE;
                if (ROM_PROTECT && (32'(addr_q) < ROM_WORDS)) proto_err = 1'b1;
                else                                          mem_we    = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_bus            = tx_byte;
    assign bus.ard_data_ready    = drdy;
    assign bus.ard_receive_ready = rrdy;

endmodule

// File: tb/tb_serial_bus_responder.sv
// Self-checking bench: word-transaction table with a response scoreboard, plus hand-written corner sequences.
module tb_serial_bus_responder;
    import serial_bus_responder_pkg::*;

`ifdef SBR_ROM_PROTECT_EN
    localparam bit ROM_ON = 1'b1;
`else
    localparam bit ROM_ON = 1'b0;
`endif
    localparam int RESP_LAT = 2;

    typedef struct {
        logic        pc;
        logic        mar;
        logic        mdr;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          n;
        logic [31:0] rsp;
        bit          wr;
        bit          wr_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        proto_err;
    logic        init_we = 1'b0;
    logic [7:0]  init_addr = '0;
    logic [15:0] init_data = '0;

    int          checks = 0;
    int          errors = 0;
    logic        s_err, s_rrdy, s_drdy;
    logic [7:0]  s_inb;
    logic [7:0]  sb[$];
    vec_t        vecs[11];
    vec_t        v_init;

    serial_bus_responder_if bus ();

    serial_bus_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .proto_err (proto_err),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response bytes are compared in order against what the stimulus queued.
    always @(negedge clk) begin
        if (rst && bus.ard_data_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %h expected none at %0t", bus.in_bus, $time);
            end else begin
                check("rsp_byte", {8'h00, bus.in_bus}, {8'h00, sb.pop_front()});
            end
        end
    end

    task automatic cycle(input logic pc, input logic mar, input logic mdr, input logic [7:0] d);
        @(negedge clk);
        bus.bus_pc  = pc;
        bus.bus_mar = mar;
        bus.bus_mdr = mdr;
        bus.out_bus = d;
        #1;
        s_err  = proto_err;
        s_rrdy = bus.ard_receive_ready;
        s_drdy = bus.ard_data_ready;
        s_inb  = bus.in_bus;
        @(posedge clk);
        #1;
        bus.bus_pc  = 1'b0;
        bus.bus_mar = 1'b0;
        bus.bus_mdr = 1'b0;
        bus.out_bus = 8'h00;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(posedge clk);
        #1;
        init_we = 1'b0;
    endtask

    task automatic expect_resp(input int n, input logic [31:0] b);
        for (int i = 0; i < n; i++) sb.push_back(b[31-8*i -: 8]);
        for (int i = 0; i < RESP_LAT; i++) begin
            idle();
            check("wait_rrdy", 16'(s_rrdy), 16'd0);
            check("wait_drdy", 16'(s_drdy), 16'd0);
            check("wait_in_bus", 16'(s_inb), 16'd0);
        end
        for (int i = 0; i < n; i++) begin
            idle();
            check("tx_drdy", 16'(s_drdy), 16'd1);
        end
        idle();
        check("end_drdy", 16'(s_drdy), 16'd0);
        check("end_rrdy", 16'(s_rrdy), 16'd1);
        check("end_in_bus", 16'(s_inb), 16'd0);
    endtask

    task automatic run_vec(input vec_t v);
        cycle(v.pc, v.mar, v.mdr, v.hi);
        check("hi_rrdy", 16'(s_rrdy), 16'd1);
        check("hi_err", 16'(s_err), 16'd0);
        cycle(v.pc, v.mar, v.mdr, v.lo);
        check("lo_err", 16'(s_err), 16'd0);
        if (v.n > 0) begin
            expect_resp(v.n, v.rsp);
        end else if (v.wr) begin
            idle();
            check("wr_rrdy", 16'(s_rrdy), 16'd0);
            check("wr_err", 16'(s_err), 16'(v.wr_err));
            idle();
            check("post_wr_rrdy", 16'(s_rrdy), 16'd1);
        end else begin
            idle();
            check("mdr_rrdy", 16'(s_rrdy), 16'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.bus_pc  = 1'b0;
        bus.bus_mar = 1'b0;
        bus.bus_mdr = 1'b0;
        bus.halt    = 1'b0;
        bus.out_bus = 8'h00;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 4, 32'h1234_ABCD, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 4, 32'h0F0F_5555, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 2, 32'h1234_0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h09, 4, 32'hC3A5_7E81, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h0A, 2, 32'h7E81_0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hBE, 8'hEF, 0, 32'h0,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 0, 32'h0,         1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 2, 32'hBEEF_0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 0, 32'h0,         1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 0, 32'h0,         1'b1, ROM_ON};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 2,
                     ROM_ON ? 32'h0000_0000 : 32'h1234_0000, 1'b0, 1'b0};
        v_init   = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 4, 32'h9999_4142, 1'b0, 1'b0};

        // Outputs held at zero while reset is asserted.
        #3;
        check("rst_rrdy", 16'(bus.ard_receive_ready), 16'd0);
        check("rst_drdy", 16'(bus.ard_data_ready), 16'd0);
        check("rst_in_bus", 16'(bus.in_bus), 16'd0);
        check("rst_perr", 16'(proto_err), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle();
        check("post_rst_rrdy", 16'(s_rrdy), 16'd1);
        check("post_rst_perr", 16'(s_err), 16'd0);

        preload(8'h00, 16'h5555);
        preload(8'h03, 16'h0000);
        preload(8'h04, 16'h1234);
        preload(8'h05, 16'hABCD);
        preload(8'h09, 16'hC3A5);
        preload(8'h0A, 16'h7E81);
        preload(8'h41, 16'h4142);
        preload(8'hFF, 16'h0F0F);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Lo byte never arrives: error on the TIMEOUT-th empty cycle.
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 15; i++) begin
            idle();
            check("tmo_err", 16'(s_err), 16'(i == 15));
            check("tmo_rrdy", 16'(s_rrdy), 16'd1);
        end
        run_vec(vecs[0]);

        // Kind change mid-word restarts with the new byte as hi.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("kind_err", 16'(s_err), 16'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h04);
        check("kind_lo_err", 16'(s_err), 16'd0);
        expect_resp(2, 32'h1234_0000);

        // Two selects at once: error, byte dropped.
        cycle(1'b1, 1'b1, 1'b0, 8'h33);
        check("multi_err", 16'(s_err), 16'd1);
        idle();
        check("multi_rrdy", 16'(s_rrdy), 16'd1);
        check("multi_err_clr", 16'(s_err), 16'd0);
        run_vec(vecs[0]);

        // Preload colliding with an accepted byte: write wins.
        init_we   = 1'b1;
        init_addr = 8'h40;
        init_data = 16'h9999;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        init_we = 1'b0;
        check("init_clash_err", 16'(s_err), 16'd1);
        run_vec(v_init);

        // Preload outside S_IDLE is ignored.
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        init_we   = 1'b1;
        init_addr = 8'h04;
        init_data = 16'hDEAD;
        cycle(1'b0, 1'b1, 1'b0, 8'h04);
        init_we = 1'b0;
        expect_resp(2, 32'h1234_0000);

        // Halt: in-flight response completes, new bytes ignored.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h04);
        bus.halt = 1'b1;
        expect_resp(4, 32'h1234_ABCD);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("halt_err", 16'(s_err), 16'd0);
        idle();
        bus.halt = 1'b0;
        run_vec(vecs[0]);

        // Reset during S_TX clears outputs immediately; memory survives.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h04);
        idle();
        idle();
        sb.push_back(8'h12);
        @(negedge clk);
        #2;
        check("tx_before_rst", 16'(bus.ard_data_ready), 16'd1);
        rst = 1'b0;
        #1;
        check("midrst_drdy", 16'(bus.ard_data_ready), 16'd0);
        check("midrst_in_bus", 16'(bus.in_bus), 16'd0);
        check("midrst_rrdy", 16'(bus.ard_receive_ready), 16'd0);
        check("midrst_perr", 16'(proto_err), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0]);

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
